store_buffer: RTL and testbench

- Write-posting buffer between the MEM-stage datapath and the word-addressed data memory (12-bit word address, single shared address port, combinational read, full-word write on clk edge when write enable high).
- Accepts byte/half/word stores and retires them to memory in idle load cycles, using read-modify-write for partial words.
- Forwards pending store bytes to same-cycle loads, youngest entry wins.
- Load sign/zero extension is done downstream, not here.

---
 rtl/store_buffer_pkg.sv | 19 +
 rtl/store_lane_align.sv | 30 +++
 rtl/store_buffer.sv | 112 +++++++++++
 tb/tb_store_buffer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer: size codes, default geometry, entry layout.
package store_buffer_pkg;

    localparam int DEPTH_DEF = 4;
    localparam int AW_DEF    = 12;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // One posted store. The address field is sized to the default AW,
    // so instances must not use a wider AW.
    typedef struct packed {
        logic [AW_DEF-1:0] word_addr;
        logic [31:0]       data;
        logic [3:0]        be;
    } entry_t;

endpackage

// File: rtl/store_lane_align.sv
// Places a right-aligned store value onto its byte lanes and builds the byte enables.
module store_lane_align
    import store_buffer_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] data,
    output logic [3:0]  be,
    output logic [31:0] aligned
);

    // Replicate the value across lanes and enable only the targeted ones;
    // the unused size code behaves as a full word.
    always_comb begin
        be      = 4'b1111;
        aligned = data;
        case (size)
            SZ_BYTE: begin
                be      = 4'b0001 << addr_lo;
                aligned = {4{data[7:0]}};
            end
            SZ_HALF: begin
                be      = addr_lo[1] ? 4'b1100 : 4'b0011;
                aligned = {2{data[15:0]}};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// Write-posting buffer: queues stores, retires them in idle memory cycles
// (read-modify-write for partial words), and forwards pending bytes to loads.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          st_valid,
    input  logic [AW+1:0] st_addr,
    input  logic [1:0]    st_size,
    input  logic [31:0]   st_data,
    input  logic          ld_valid,
    input  logic [AW+1:0] ld_addr,
    output logic [31:0]   ld_word,
    output logic          stall,
    output logic          empty,
    output logic [AW-1:0] dm_addr,
    output logic [31:0]   dm_wdata,
    output logic          dm_we,
    input  logic [31:0]   dm_rdata
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    entry_t         fifo [DEPTH];
    logic [PW-1:0]  head, tail;
    logic [CW-1:0]  count;

    logic           full, drain, load, enq;
    logic [3:0]     al_be;
    logic [31:0]    al_data;
    logic [AW_DEF-1:0] ld_waddr;
    logic           unused_ld_lo;

    assign unused_ld_lo = ^ld_addr[1:0];
    assign ld_waddr     = AW_DEF'(ld_addr[AW+1:2]);

    store_lane_align u_align (
        .size    (st_size),
        .addr_lo (st_addr[1:0]),
        .data    (st_data),
        .be      (al_be),
        .aligned (al_data)
    );

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign stall = full && (st_valid || ld_valid);
    // Draining wins the port when full so a stalled pipeline always makes progress.
    assign drain = !empty && (full || !ld_valid);
    assign load  = !drain && ld_valid;
    assign enq   = st_valid && !stall;

    // Store a newly accepted entry at the tail; contents need no reset since count gates them.
    always_ff @(posedge clk) begin
        if (enq)
            fifo[tail] <= '{word_addr: AW_DEF'(st_addr[AW+1:2]), data: al_data, be: al_be};
    end

    // Pointer and occupancy bookkeeping; drain and enqueue in one cycle cancel out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (drain) head <= head + 1'b1;
            if (enq)   tail <= tail + 1'b1;
            case ({enq, drain})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Forwarding: walk oldest to youngest so the youngest matching byte lands last.
    always_comb begin
        logic [PW-1:0] idx;
        ld_word = dm_rdata;
        idx     = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (CW'(i) < count && fifo[idx].word_addr == ld_waddr) begin
                for (int b = 0; b < 4; b++)
                    if (fifo[idx].be[b])
                        ld_word[b*8 +: 8] = fifo[idx].data[b*8 +: 8];
            end
        end
    end

    // Memory port arbitration: drain (RMW merge over the read word), else load, else idle.
    always_comb begin
        dm_addr  = '0;
        dm_wdata = '0;
        dm_we    = 1'b0;
        if (drain) begin
            dm_addr = AW'(fifo[head].word_addr);
            dm_we   = 1'b1;
            for (int b = 0; b < 4; b++)
                dm_wdata[b*8 +: 8] = fifo[head].be[b] ? fifo[head].data[b*8 +: 8]
                                                      : dm_rdata[b*8 +: 8];
        end else if (load) begin
            dm_addr = ld_addr[AW+1:2];
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus a randomized run,
// all checked against a queue-of-pending-stores reference model.
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          st_valid = 1'b0;
    logic [AW+1:0] st_addr = '0;
    logic [1:0]    st_size = '0;
    logic [31:0]   st_data = '0;
    logic          ld_valid = 1'b0;
    logic [AW+1:0] ld_addr = '0;
    logic [31:0]   ld_word;
    logic          stall, empty;
    logic [AW-1:0] dm_addr;
    logic [31:0]   dm_wdata;
    logic          dm_we;
    logic [31:0]   dm_rdata;

    logic [31:0] mem  [4096];   // memory seen by the DUT
    logic [31:0] mmem [4096];   // reference memory image

    typedef struct packed {
        logic [11:0]     wa;
        logic [3:0][7:0] b;
        logic [3:0]      m;
    } ment_t;
    ment_t mq[$];

    int checks = 0;
    int failures = 0;
    int overlaps = 0;

    // observed values from the most recent step
    logic        o_stall, o_we;
    logic [11:0] o_addr;
    logic [31:0] o_wdata, o_ld;

    assign dm_rdata = mem[dm_addr];

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_addr(st_addr), .st_size(st_size), .st_data(st_data),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_word(ld_word),
        .stall(stall), .empty(empty),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_rdata(dm_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s at %0t: got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    function automatic ment_t mk(input logic [13:0] a, input logic [1:0] sz, input logic [31:0] d);
        ment_t e;
        int    base;
        e.wa = a[13:2];
        e.b  = '0;
        e.m  = '0;
        if (sz == 2'd0) begin
            e.m[a[1:0]] = 1'b1;
            e.b[a[1:0]] = d[7:0];
        end else if (sz == 2'd1) begin
            base = a[1] ? 2 : 0;
            e.m[base] = 1'b1;  e.b[base]   = d[7:0];
            e.m[base+1] = 1'b1; e.b[base+1] = d[15:8];
        end else begin
            e.m = 4'hF;
            for (int k = 0; k < 4; k++) e.b[k] = d[k*8 +: 8];
        end
        return e;
    endfunction

    function automatic logic [31:0] overlay(input logic [31:0] w, input ment_t e);
        for (int k = 0; k < 4; k++)
            if (e.m[k]) w[k*8 +: 8] = e.b[k];
        return w;
    endfunction

    // One clock cycle: drive, check against the model, advance model and memory.
    task automatic step(input bit stv, input logic [13:0] sa, input logic [1:0] sz,
                        input logic [31:0] sd, input bit ldv, input logic [13:0] la);
        int          n;
        bit          full, drn, lod, stl;
        logic [31:0] exp_w, exp_ld;
        logic [11:0] exp_a;
        logic        cap_we;
        logic [11:0] cap_a;
        logic [31:0] cap_d;
        st_valid = stv; st_addr = sa; st_size = sz; st_data = sd;
        ld_valid = ldv; ld_addr = la;
        #1;
        n    = mq.size();
        full = (n == DEPTH);
        drn  = (n > 0) && (full || !ldv);
        lod  = !drn && ldv;
        stl  = full && (stv || ldv);
        exp_a = drn ? mq[0].wa : (lod ? la[13:2] : 12'h0);
        exp_w = drn ? overlay(mmem[mq[0].wa], mq[0]) : 32'h0;
        o_stall = stall; o_we = dm_we; o_addr = dm_addr; o_wdata = dm_wdata; o_ld = ld_word;
        chk("stall", {31'b0, stall}, {31'b0, stl});
        chk("empty", {31'b0, empty}, {31'b0, n == 0});
        chk("dm_we", {31'b0, dm_we}, {31'b0, drn});
        chk("dm_addr", {20'b0, dm_addr}, {20'b0, exp_a});
        chk("dm_wdata", dm_wdata, exp_w);
        if (lod && !stl) begin
            exp_ld = mmem[la[13:2]];
            foreach (mq[i]) if (mq[i].wa == la[13:2]) exp_ld = overlay(exp_ld, mq[i]);
            chk("ld_word", ld_word, exp_ld);
        end
        if (stv && ldv) overlaps++;
        if (drn) begin
            mmem[mq[0].wa] = exp_w;
            void'(mq.pop_front());
        end
        if (stv && !stl) mq.push_back(mk(sa, sz, sd));
        cap_we = dm_we; cap_a = dm_addr; cap_d = dm_wdata;
        @(posedge clk);
        if (cap_we) mem[cap_a] = cap_d;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, '0, '0, 0, '0);
    endtask

    initial begin
        bit          pv, pl;
        logic [13:0] pa, pla;
        logic [1:0]  ps;
        logic [31:0] pd;
        int          tries;

        for (int i = 0; i < 4096; i++) begin
            mem[i]  = $urandom;
            mmem[i] = mem[i];
        end
        mem[5] = 32'h11223344; mmem[5] = 32'h11223344;
        mem[8] = 32'h0;        mmem[8] = 32'h0;

        // reset state
        #2;
        chk("rst_empty", {31'b0, empty}, 32'd1);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_we", {31'b0, dm_we}, 32'd0);
        chk("rst_addr", {20'b0, dm_addr}, 32'd0);
        chk("rst_wdata", dm_wdata, 32'd0);
        chk("rst_ldword", ld_word, mmem[0]);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // word store then idle: drains next cycle
        step(1, 14'h0010, 2'd2, 32'hDEADBEEF, 0, '0);
        step(0, '0, '0, '0, 0, '0);
        chk("t1_we", {31'b0, o_we}, 32'd1);
        chk("t1_addr", {20'b0, o_addr}, 32'h004);
        chk("t1_wdata", o_wdata, 32'hDEADBEEF);
        idle(1);
        chk("t1_empty", {31'b0, empty}, 32'd1);

        // partial store read-modify-write
        step(1, 14'h0016, 2'd0, 32'h000000AB, 0, '0);
        step(0, '0, '0, '0, 0, '0);
        chk("t2_wdata", o_wdata, 32'h11AB3344);

        // forwarding, youngest wins; load held high keeps both entries pending
        step(1, 14'h0020, 2'd1, 32'h00005555, 1, 14'h0020);
        step(1, 14'h0021, 2'd0, 32'h00000077, 1, 14'h0020);
        for (int i = 0; i < 3; i++) begin
            step(0, '0, '0, '0, 1, 14'h0020);
            chk("t3_fwd", o_ld, 32'h00007755);
            chk("t3_nodrain", {31'b0, o_we}, 32'd0);
        end
        idle(3);
        chk("t3_mem", mem[8], 32'h00007755);

        // full buffer: back-to-back stores under continuous loads
        begin
            logic [13:0] fa [5] = '{14'h0040, 14'h0044, 14'h0040, 14'h0048, 14'h0040};
            for (int k = 0; k < 5; k++) begin
                tries = 0;
                step(1, fa[k], 2'd2, 32'hA0000000 + k, 1, 14'h0004);
                if (k == DEPTH) chk("t4_stall", {31'b0, o_stall}, 32'd1);
                while (o_stall && tries < 8) begin
                    tries++;
                    step(1, fa[k], 2'd2, 32'hA0000000 + k, 1, 14'h0004);
                end
                chk("t4_accept", {31'b0, o_stall}, 32'd0);
            end
            idle(DEPTH + 1);
            chk("t4_order", mem[16], 32'hA0000004);
            chk("t4_empty", {31'b0, empty}, 32'd1);
        end

        // reset mid-operation
        for (int k = 0; k < 3; k++) step(1, 14'(14'h0080 + 4 * k), 2'd2, $urandom, 1, 14'h0000);
        st_valid = 0; ld_valid = 0; ld_addr = '0;
        #1;
        chk("t5_predrain", {31'b0, dm_we}, 32'd1);
        reset = 1'b0;
        #1;
        chk("t5_empty", {31'b0, empty}, 32'd1);
        chk("t5_we", {31'b0, dm_we}, 32'd0);
        chk("t5_addr", {20'b0, dm_addr}, 32'd0);
        chk("t5_wdata", dm_wdata, 32'd0);
        chk("t5_stall", {31'b0, stall}, 32'd0);
        chk("t5_ldword", ld_word, mmem[0]);
        @(posedge clk); #1;
        reset = 1'b1;
        mq.delete();
        idle(4);
        for (int k = 0; k < 3; k++) chk("t5_nowrite", mem[32 + k], mmem[32 + k]);

        // randomized traffic with stall retry
        pv = 0; pl = 0; pa = '0; pla = '0; ps = '0; pd = '0;
        for (int c = 0; c < 400; c++) begin
            if (!o_stall || c == 0) begin
                pv  = ($urandom_range(0, 9) < 6);
                pl  = ($urandom_range(0, 9) < 5);
                pa  = 14'($urandom_range(0, 63));
                pla = 14'($urandom_range(0, 63));
                ps  = 2'($urandom_range(0, 3));
                pd  = $urandom;
            end
            step(pv, pa, ps, pd, pl, pla);
        end
        idle(DEPTH + 1);
        chk("rnd_empty", {31'b0, empty}, 32'd1);
        for (int w = 0; w < 48; w++) chk("rnd_mem", mem[w], mmem[w]);

        $display("note: %0d cycles carried both a store and a load (protocol warning)", overlaps);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
